// File: rtl/sram_scan_master.sv
// Tester-side scan driver for the SRAM scan test chip: target reset, {addr,cnt,write}
// header, then write bytes shifted out or read bytes captured from scan_out, LSB first.
module sram_scan_master #(
    parameter int N_ADDR  = 12,
    parameter int N_CNT   = 13,
    parameter int N_DATA  = 8,
    parameter int RST_CYC = 4,
    parameter int RD_LAT  = 2
) (
    input  logic              clk_1,
    input  logic              rst_n_sync,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [N_ADDR-1:0] cmd_addr,
    input  logic [N_CNT-2:0]  cmd_cnt,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [N_DATA-1:0] wdata,
    output logic              rdata_valid,
    output logic [N_DATA-1:0] rdata,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              underrun,
    output logic              scan_rst_n,
    output logic              scan_in,
    input  logic              scan_out
);

    localparam int HDR_LEN = N_ADDR + N_CNT;
    localparam int CW      = $clog2(HDR_LEN + RST_CYC + RD_LAT + N_DATA);

    localparam logic [CW-1:0]      TRST_LAST = CW'(RST_CYC - 1);
    localparam logic [CW-1:0]      HDR_LAST  = CW'(HDR_LEN - 1);
    localparam logic [CW-1:0]      BYTE_LAST = CW'(N_DATA - 1);
    localparam logic [CW-1:0]      SKIP_LAST = CW'(RD_LAT - 1);
    localparam logic [CW-1:0]      BIT_ONE   = CW'(1);
    localparam logic [N_CNT-2:0]   WORD_ONE  = (N_CNT-1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRST,
        S_HDR,
        S_WDATA,
        S_RSKIP,
        S_RDATA,
        S_DONE
    } state_t;

    state_t               state;
    logic [CW-1:0]        bit_cnt;
    logic [N_CNT-2:0]     word_cnt;
    logic [HDR_LEN-1:0]   hdr_sr;
    logic [N_DATA-1:0]    data_sr;
    logic                 is_write;
    logic                 accept;
    logic [N_DATA-1:0]    load_byte;
    logic [N_DATA-1:0]    rd_shift;

    // abort wins over a simultaneous command request, so the handshake is withheld.
    assign cmd_ready   = (state == S_IDLE) && !abort;
    assign accept      = cmd_valid && cmd_ready;
    assign wdata_ready = !abort && (bit_cnt == '0) &&
                         ((state == S_HDR && is_write) || (state == S_WDATA && word_cnt != '0));
    // A missing write byte is replaced by zeros; the scan line never stalls.
    assign load_byte   = wdata_valid ? wdata : '0;
    assign rd_shift    = {scan_out, data_sr[N_DATA-1:1]};

    // NOTE: all state uses non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk_1 or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            state       <= S_IDLE;
            bit_cnt     <= '0;
            word_cnt    <= '0;
            hdr_sr      <= '0;
            data_sr     <= '0;
            is_write    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            underrun    <= 1'b0;
            rdata_valid <= 1'b0;
            rdata       <= '0;
            scan_rst_n  <= 1'b0;
            scan_in     <= 1'b0;
        end else begin
            done        <= 1'b0;
            underrun    <= 1'b0;
            rdata_valid <= 1'b0;
            if (state != S_IDLE && abort) begin
                state      <= S_IDLE;
                busy       <= 1'b0;
                scan_rst_n <= 1'b0;
                scan_in    <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (accept) begin
                            state    <= S_TRST;
                            busy     <= 1'b1;
                            hdr_sr   <= {cmd_addr, cmd_cnt, cmd_write};
                            word_cnt <= cmd_cnt;
                            is_write <= cmd_write;
                            bit_cnt  <= TRST_LAST;
                        end
                    end
                    S_TRST: begin
                        if (bit_cnt == '0) begin
                            state      <= S_HDR;
                            bit_cnt    <= HDR_LAST;
                            scan_rst_n <= 1'b1;
                            scan_in    <= hdr_sr[0];
                            hdr_sr     <= hdr_sr >> 1;
                        end else begin
                            bit_cnt <= bit_cnt - BIT_ONE;
                        end
                    end
                    S_HDR: begin
                        if (bit_cnt != '0) begin
                            scan_in <= hdr_sr[0];
                            hdr_sr  <= hdr_sr >> 1;
                            bit_cnt <= bit_cnt - BIT_ONE;
                        end else if (is_write) begin
                            state    <= S_WDATA;
                            bit_cnt  <= BYTE_LAST;
                            scan_in  <= load_byte[0];
                            data_sr  <= load_byte >> 1;
                            underrun <= !wdata_valid;
                        end else begin
                            state   <= S_RSKIP;
                            bit_cnt <= SKIP_LAST;
                            scan_in <= 1'b0;
                        end
                    end
                    S_WDATA: begin
                        if (bit_cnt != '0) begin
                            scan_in <= data_sr[0];
                            data_sr <= data_sr >> 1;
                            bit_cnt <= bit_cnt - BIT_ONE;
                        end else if (word_cnt == '0) begin
                            state      <= S_DONE;
                            done       <= 1'b1;
                            scan_rst_n <= 1'b0;
                            scan_in    <= 1'b0;
                        end else begin
                            word_cnt <= word_cnt - WORD_ONE;
                            bit_cnt  <= BYTE_LAST;
                            scan_in  <= load_byte[0];
                            data_sr  <= load_byte >> 1;
                            underrun <= !wdata_valid;
                        end
                    end
                    S_RSKIP: begin
                        if (bit_cnt == '0) begin
                            state   <= S_RDATA;
                            bit_cnt <= BYTE_LAST;
                        end else begin
                            bit_cnt <= bit_cnt - BIT_ONE;
                        end
                    end
                    S_RDATA: begin
                        data_sr <= rd_shift;
                        if (bit_cnt != '0) begin
                            bit_cnt <= bit_cnt - BIT_ONE;
                        end else begin
                            rdata       <= rd_shift;
                            rdata_valid <= 1'b1;
                            if (word_cnt == '0) begin
                                state      <= S_DONE;
                                done       <= 1'b1;
                                scan_rst_n <= 1'b0;
                            end else begin
                                word_cnt <= word_cnt - WORD_ONE;
                                bit_cnt  <= BYTE_LAST;
                            end
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sram_scan_master.sv
// Self-checking bench for sram_scan_master: directed command table, randomized commands,
// abort and mid-command reset sequences, and a maximum-length read.
module tb_sram_scan_master;

    localparam int HDR_LEN = 25;

    logic        clk_1 = 1'b0;
    logic        rst_n_sync = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [11:0] cmd_addr = '0;
    logic [11:0] cmd_cnt = '0;
    logic        wdata_valid = 1'b0;
    logic        wdata_ready;
    logic [7:0]  wdata = '0;
    logic        rdata_valid;
    logic [7:0]  rdata;
    logic        abort = 1'b0;
    logic        busy;
    logic        done;
    logic        underrun;
    logic        scan_rst_n;
    logic        scan_in;
    logic        scan_out = 1'b0;

    sram_scan_master dut (
        .clk_1       (clk_1),
        .rst_n_sync  (rst_n_sync),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_cnt     (cmd_cnt),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .wdata       (wdata),
        .rdata_valid (rdata_valid),
        .rdata       (rdata),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .underrun    (underrun),
        .scan_rst_n  (scan_rst_n),
        .scan_in     (scan_in),
        .scan_out    (scan_out)
    );

    always #5 clk_1 = ~clk_1;

    int n_pass = 0;
    int n_total = 0;

    // Per-command payload: write bytes (with availability flags) or chip read bytes.
    logic [7:0] cmd_bytes [4096];
    bit         cmd_flags [4096];

    typedef struct {
        logic        write;
        logic [11:0] addr;
        logic [11:0] cnt;
        logic [31:0] data;
        logic [3:0]  vmask;
        int          exp_ready;
        int          exp_under;
        int          exp_rv;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Issues one command and compares every cycle against the cycle-level timeline:
    // cycles 0..3 target reset, 4..28 header, then data, then one done cycle.
    // stop_at >= 0 returns at the negedge of that cycle with the command still running.
    task automatic run_cmd(input string tag, input logic w, input logic [11:0] a,
                           input logic [11:0] c, input int stop_at,
                           output int n_rdy, output int n_und, output int n_rv,
                           output logic [24:0] hdr_cap);
        int L, dstart, d_cyc, wptr, j, b;
        int e_si, e_rst, e_busy, e_done, e_rdy, e_und, e_rv, e_rd;
        logic [24:0] hdr_exp;
        logic exp_si, exp_rst, exp_busy, exp_done, exp_rdy, exp_und, exp_rv;
        L       = 8 * (int'(c) + 1);
        dstart  = w ? 29 : 31;
        d_cyc   = dstart + L;
        hdr_exp = {a, c, w};
        hdr_cap = '0;
        n_rdy = 0; n_und = 0; n_rv = 0; wptr = 0;
        e_si = 0; e_rst = 0; e_busy = 0; e_done = 0; e_rdy = 0; e_und = 0; e_rv = 0; e_rd = 0;
        @(negedge clk_1);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_cnt = c;
        @(negedge clk_1);
        cmd_valid = 1'b0;
        for (int cyc = 0; cyc <= d_cyc + 1; cyc++) begin
            if (cyc > 0) @(negedge clk_1);
            if (cyc == stop_at) break;
            if (wptr < 4096) begin
                wdata = cmd_bytes[wptr]; wdata_valid = cmd_flags[wptr];
            end else begin
                wdata = '0; wdata_valid = 1'b0;
            end
            exp_busy = (cyc <= d_cyc);
            exp_done = (cyc == d_cyc);
            exp_rst  = (cyc >= 4 && cyc < d_cyc);
            exp_si   = 1'b0;
            exp_rdy  = 1'b0;
            exp_und  = 1'b0;
            exp_rv   = 1'b0;
            if (cyc >= 4 && cyc < 4 + HDR_LEN) exp_si = hdr_exp[cyc-4];
            if (w) begin
                if (cyc >= 29 && cyc < d_cyc) begin
                    j = (cyc - 29) / 8; b = (cyc - 29) % 8;
                    exp_si  = cmd_flags[j] ? cmd_bytes[j][b] : 1'b0;
                    exp_und = (b == 0) && !cmd_flags[j];
                    exp_rdy = (b == 7) && (cyc < d_cyc - 8);
                end
                if (cyc == 28) exp_rdy = 1'b1;
            end else if (cyc >= 39 && (cyc - 39) % 8 == 0 && (cyc - 39) / 8 <= int'(c)) begin
                exp_rv = 1'b1;
                if (rdata !== cmd_bytes[(cyc-39)/8]) e_rd++;
            end
            if (scan_in !== exp_si) e_si++;
            if (scan_rst_n !== exp_rst) e_rst++;
            if (busy !== exp_busy || cmd_ready !== !exp_busy) e_busy++;
            if (done !== exp_done) e_done++;
            if (wdata_ready !== exp_rdy) e_rdy++;
            if (underrun !== exp_und) e_und++;
            if (rdata_valid !== exp_rv) e_rv++;
            if (cyc >= 4 && cyc < 4 + HDR_LEN) hdr_cap[cyc-4] = scan_in;
            if (wdata_ready) begin n_rdy++; wptr++; end
            if (underrun) n_und++;
            if (rdata_valid) n_rv++;
            if (!w && cyc >= 31 && cyc < d_cyc)
                scan_out = cmd_bytes[(cyc-31)/8][(cyc-31)%8];
            else
                scan_out = 1'($urandom_range(0, 1));
        end
        wdata_valid = 1'b0;
        check({tag, " scan_in cycles wrong"},    32'(e_si),   32'd0);
        check({tag, " scan_rst_n cycles wrong"}, 32'(e_rst),  32'd0);
        check({tag, " busy/ready cycles wrong"}, 32'(e_busy), 32'd0);
        check({tag, " done cycles wrong"},       32'(e_done), 32'd0);
        check({tag, " wdata_ready cycles wrong"},32'(e_rdy),  32'd0);
        check({tag, " underrun cycles wrong"},   32'(e_und),  32'd0);
        check({tag, " rdata_valid cycles wrong"},32'(e_rv),   32'd0);
        check({tag, " rdata bytes wrong"},       32'(e_rd),   32'd0);
        if (stop_at < 0) check({tag, " header"}, 32'(hdr_cap), 32'(hdr_exp));
    endtask

    initial begin
        int n_rdy, n_und, n_rv, cnt_ev;
        int exp_und;
        logic [24:0] hdr;
        logic        w;
        logic [11:0] a, c;

        vecs[0] = '{1'b1, 12'h010, 12'd2, 32'h00FF3CA5, 4'b0111, 3, 0, 0};
        vecs[1] = '{1'b0, 12'hABC, 12'd1, 32'h00007E81, 4'b0000, 0, 0, 2};
        vecs[2] = '{1'b1, 12'h3FF, 12'd0, 32'h0000005A, 4'b0000, 1, 1, 0};
        vecs[3] = '{1'b1, 12'hFFF, 12'd3, 32'h44332211, 4'b0101, 4, 2, 0};
        vecs[4] = '{1'b0, 12'h000, 12'd0, 32'h000000C3, 4'b0000, 0, 0, 1};

        // Reset values while rst_n_sync is held low
        #2;
        check("reset scan_rst_n",  32'(scan_rst_n),  32'd0);
        check("reset scan_in",     32'(scan_in),     32'd0);
        check("reset rdata",       32'(rdata),       32'd0);
        check("reset rdata_valid", 32'(rdata_valid), 32'd0);
        check("reset done",        32'(done),        32'd0);
        check("reset underrun",    32'(underrun),    32'd0);
        check("reset busy",        32'(busy),        32'd0);
        check("reset cmd_ready",   32'(cmd_ready),   32'd1);
        check("reset wdata_ready", 32'(wdata_ready), 32'd0);
        @(negedge clk_1);
        rst_n_sync = 1'b1;

        // Directed command table
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 4; k++) begin
                cmd_bytes[k] = vecs[i].data[8*k +: 8];
                cmd_flags[k] = vecs[i].vmask[k];
            end
            run_cmd($sformatf("vec%0d", i), vecs[i].write, vecs[i].addr, vecs[i].cnt, -1,
                    n_rdy, n_und, n_rv, hdr);
            check($sformatf("vec%0d wdata_ready count", i), 32'(n_rdy), 32'(vecs[i].exp_ready));
            check($sformatf("vec%0d underrun count", i),    32'(n_und), 32'(vecs[i].exp_under));
            check($sformatf("vec%0d rdata_valid count", i), 32'(n_rv),  32'(vecs[i].exp_rv));
        end

        // Randomized commands
        for (int i = 0; i < 10; i++) begin
            w = 1'($urandom_range(0, 1));
            a = 12'($urandom);
            c = 12'($urandom_range(0, 5));
            exp_und = 0;
            for (int k = 0; k <= int'(c); k++) begin
                cmd_bytes[k] = 8'($urandom);
                cmd_flags[k] = ($urandom_range(0, 3) != 0);
                if (w && !cmd_flags[k]) exp_und++;
            end
            run_cmd($sformatf("rnd%0d", i), w, a, c, -1, n_rdy, n_und, n_rv, hdr);
            check($sformatf("rnd%0d wdata_ready count", i), 32'(n_rdy), w ? 32'(int'(c) + 1) : 32'd0);
            check($sformatf("rnd%0d underrun count", i),    32'(n_und), 32'(exp_und));
            check($sformatf("rnd%0d rdata_valid count", i), 32'(n_rv),  w ? 32'd0 : 32'(int'(c) + 1));
        end

        // Abort during header bit 10
        for (int k = 0; k < 8; k++) begin cmd_bytes[k] = 8'($urandom); cmd_flags[k] = 1'b1; end
        run_cmd("abort", 1'b1, 12'h155, 12'd7, 14, n_rdy, n_und, n_rv, hdr);
        check("abort pre scan_rst_n", 32'(scan_rst_n), 32'd1);
        abort = 1'b1;
        @(negedge clk_1);
        check("abort busy",       32'(busy),       32'd0);
        check("abort scan_rst_n", 32'(scan_rst_n), 32'd0);
        check("abort scan_in",    32'(scan_in),    32'd0);
        check("abort done",       32'(done),       32'd0);
        abort = 1'b0;
        #1;
        check("abort cmd_ready",  32'(cmd_ready),  32'd1);
        cnt_ev = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_1);
            if (done || busy) cnt_ev++;
        end
        check("abort no done afterwards", 32'(cnt_ev), 32'd0);

        // Reset during the second read byte
        cmd_bytes[0] = 8'h81; cmd_bytes[1] = 8'h7E;
        run_cmd("rst_mid", 1'b0, 12'hABC, 12'd1, 42, n_rdy, n_und, n_rv, hdr);
        check("rst_mid rdata held", 32'(rdata), 32'h81);
        #2 rst_n_sync = 1'b0;
        #1;
        check("rst_mid busy",        32'(busy),        32'd0);
        check("rst_mid scan_rst_n",  32'(scan_rst_n),  32'd0);
        check("rst_mid scan_in",     32'(scan_in),     32'd0);
        check("rst_mid rdata",       32'(rdata),       32'd0);
        check("rst_mid rdata_valid", 32'(rdata_valid), 32'd0);
        check("rst_mid done",        32'(done),        32'd0);
        check("rst_mid cmd_ready",   32'(cmd_ready),   32'd1);
        cnt_ev = 0;
        for (int k = 0; k < 22; k++) begin
            @(negedge clk_1);
            if (k == 2) rst_n_sync = 1'b1;
            if (rdata_valid || busy) cnt_ev++;
        end
        check("rst_mid no activity afterwards", 32'(cnt_ev), 32'd0);

        // Maximum-length read: 4096 words
        for (int k = 0; k < 4096; k++) cmd_bytes[k] = 8'($urandom);
        run_cmd("max_read", 1'b0, 12'h5A5, 12'hFFF, -1, n_rdy, n_und, n_rv, hdr);
        check("max_read rdata_valid count", 32'(n_rv), 32'd4096);
        check("max_read header cnt field", 32'(hdr[12:1]), 32'hFFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
